// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // Owner encoding doubles as the bit index into the picker's req/gnt vectors.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Wide enough for the largest legal wait count (MEM_LATENCY up to 3).
    localparam int LAT_CNT_W = $clog2(3) + 1;

endpackage

// File: rtl/arb_pick2.sv
// Two-way combinational picker between fetch (bit OWN_I) and data (bit OWN_D).
// Build option ARB_DATA_PRIORITY_EN: when defined, data wins every conflict;
// otherwise a conflict goes to the requester that did not own the last grant.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt
);

`ifdef ARB_DATA_PRIORITY_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // One-hot grant; a lone requester always wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
`ifdef ARB_DATA_PRIORITY_EN
            2'b11:   gnt = 2'b10;
`else
            2'b11:   gnt = (last_owner == OWN_D) ? 2'b01 : 2'b10;
`endif
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and load/store.
// One transaction in flight; memory read data returns MEM_LATENCY cycles after mem_en.
// Build option ARB_DATA_PRIORITY_EN selects fixed data priority (see arb_pick2).
//
// state  | meaning
// IDLE   | arbitrate; grant pulses and the request is captured
// ACCESS | mem_en strobe with captured address/mask/data
// WAIT   | count down remaining read latency (skipped for latency 1)
// RESP   | owner's rvalid pulses, rdata taken from mem_rdata
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_owner_q, last_owner_d;
    logic                 store_q, store_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [MASK_W-1:0]    wmask_q, wmask_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]    i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]    d_rdata_q, d_rdata_d;
    logic [1:0]           pick_gnt;

    arb_pick2 u_pick (
        .req        ({d_req, i_req}),
        .last_owner (last_owner_q),
        .gnt        (pick_gnt)
    );

    // State register and captured transaction; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            store_q      <= 1'b0;
            addr_q       <= '0;
            wmask_q      <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            store_q      <= store_d;
            addr_q       <= addr_d;
            wmask_q      <= wmask_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Next-state, capture and all handshake/memory outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        store_d      = store_q;
        addr_d       = addr_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        i_rdata      = i_rdata_q;
        d_rdata      = d_rdata_q;
        mem_en       = 1'b0;
        mem_we       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                if (|pick_gnt) begin
                    i_gnt        = pick_gnt[OWN_I];
                    d_gnt        = pick_gnt[OWN_D];
                    owner_d      = pick_gnt[OWN_D] ? OWN_D : OWN_I;
                    last_owner_d = owner_d;
                    if (pick_gnt[OWN_D]) begin
                        addr_d  = d_addr;
                        store_d = d_we;
                        wmask_d = d_wmask;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = i_addr;
                        store_d = 1'b0;
                        wmask_d = '0;
                        wdata_d = '0;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
                if (store_q) begin
                    mem_we    = wmask_q;
                    mem_wdata = wdata_q;
                end
                if (MEM_LATENCY > 1) begin
                    cnt_d   = LAT_CNT_W'(MEM_LATENCY - 1);
                    state_d = WAIT;
                end else begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_CNT_W'(1);
                if (cnt_q == LAT_CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q == OWN_I) begin
                    i_rvalid  = 1'b1;
                    i_rdata   = mem_rdata;
                    i_rdata_d = mem_rdata;
                end else begin
                    d_rvalid = 1'b1;
                    // A store ack leaves the load data register untouched.
                    if (!store_q) begin
                        d_rdata   = mem_rdata;
                        d_rdata_d = mem_rdata;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
